// File: rtl/aload_sequencer.sv
// aload_sequencer
//   Drives the arst/rval inputs of a bank of async-load flip-flops through a
//   setup -> assert -> hold -> recover sequence for every accepted load request.
//   The bank's clocked d path is gated through ce_o while a sequence runs.
//   The bank output is read back twice per sequence, and any mismatch latches err.
//   Every output comes straight from a flop, so arst_o cannot glitch.

module aload_sequencer #(
    parameter int WIDTH       = 8,
    parameter int SETUP_CYC   = 1,
    parameter int ASSERT_CYC  = 2,
    parameter int HOLD_CYC    = 1,
    parameter int RECOVER_CYC = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_value,
    output logic             arst_o,
    output logic [WIDTH-1:0] rval_o,
    output logic             ce_o,
    input  logic [WIDTH-1:0] q_i,
    output logic             done,
    output logic             err
);

    // The phase counter must be wide enough to hold the longest phase length.
    localparam int MAX_SA  = (SETUP_CYC > ASSERT_CYC) ? SETUP_CYC : ASSERT_CYC;
    localparam int MAX_HR  = (HOLD_CYC > RECOVER_CYC) ? HOLD_CYC : RECOVER_CYC;
    localparam int MAX_CYC = (MAX_SA > MAX_HR) ? MAX_SA : MAX_HR;
    localparam int CNT_W   = (MAX_CYC < 1) ? 1 : $clog2(MAX_CYC + 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        ASSERT,
        HOLD,
        RECOVER
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic [CNT_W-1:0]   phase_end;
    logic               phase_last;
    logic               handshake;
    logic               mismatch;
    logic [WIDTH-1:0]   rval_d;
    logic               err_d;
    logic               done_d;
    logic               arst_d;
    logic               ce_d;
    logic               ready_d;

    // Last count value of the current phase; IDLE has no timed phase.
    always_comb begin
        // NOTE: every signal written in an always_comb gets a default first so no latch is inferred.
        phase_end = '0;
        case (state_q)
            SETUP:   phase_end = CNT_W'(SETUP_CYC - 1);
            ASSERT:  phase_end = CNT_W'(ASSERT_CYC - 1);
            HOLD:    phase_end = CNT_W'(HOLD_CYC - 1);
            RECOVER: phase_end = CNT_W'(RECOVER_CYC - 1);
            default: phase_end = '0;
        endcase
    end

    assign phase_last = (cnt_q == phase_end);
    assign handshake  = req_valid && req_ready;
    assign mismatch   = (q_i != rval_o);

    // Next-state, phase count, and next values of the registered outputs.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rval_d  = rval_o;
        err_d   = err;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (handshake) begin
                    state_d = SETUP;
                    cnt_d   = '0;
                    rval_d  = req_value;
                end
            end
            SETUP: begin
                if (phase_last) begin
                    state_d = ASSERT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ASSERT: begin
                if (phase_last) begin
                    // The bank must already show the loaded value while arst is still held.
                    if (mismatch) begin
                        err_d = 1'b1;
                    end
                    state_d = HOLD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HOLD: begin
                if (phase_last) begin
                    state_d = RECOVER;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RECOVER: begin
                if (phase_last) begin
                    // The loaded value must have survived arst release and recovery.
                    if (mismatch) begin
                        err_d = 1'b1;
                    end
                    state_d = IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // Outputs follow the state being entered, so they change on the same edge as the state.
        arst_d  = (state_d == ASSERT);
        ce_d    = (state_d == IDLE);
        ready_d = (state_d == IDLE);
    end

    // State, phase counter and output registers; rst wins over a simultaneous handshake.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            req_ready <= 1'b1;
            arst_o    <= 1'b0;
            rval_o    <= '0;
            ce_o      <= 1'b1;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            req_ready <= ready_d;
            arst_o    <= arst_d;
            rval_o    <= rval_d;
            ce_o      <= ce_d;
            done      <= done_d;
            err       <= err_d;
        end
    end

endmodule

// File: tb/tb_aload_sequencer.sv
// tb_aload_sequencer
//   Drives load requests into aload_sequencer against a behavioural async-load
//   FF bank. Each scenario records the outputs cycle by cycle, then compares them
//   with a timeline model built from the phase lengths.

module tb_aload_sequencer;

    localparam int WIDTH = 8;
    localparam int S     = 1;
    localparam int A     = 2;
    localparam int H     = 1;
    localparam int R     = 2;
    localparam int TOT   = S + A + H + R;
    localparam int NOBS  = 2 * TOT + 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] req_value;
    logic             arst_o;
    logic [WIDTH-1:0] rval_o;
    logic             ce_o;
    logic [WIDTH-1:0] q_i;
    logic             done;
    logic             err;

    // Behavioural bank: async load from rval_o, clocked d path gated by ce_o.
    logic [WIDTH-1:0] bank_q;
    logic [WIDTH-1:0] bank_d;
    logic             q_force;
    logic [WIDTH-1:0] q_force_val;

    int n_total = 0;
    int n_pass  = 0;

    logic [12:0] obs_vec [NOBS];

    always #5 clk = ~clk;

    always @(posedge clk or posedge arst_o) begin
        if (arst_o) bank_q <= rval_o;
        else if (ce_o) bank_q <= bank_d;
    end

    assign q_i = q_force ? q_force_val : bank_q;

    aload_sequencer #(
        .WIDTH(WIDTH), .SETUP_CYC(S), .ASSERT_CYC(A), .HOLD_CYC(H), .RECOVER_CYC(R)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_value (req_value),
        .arst_o    (arst_o),
        .rval_o    (rval_o),
        .ce_o      (ce_o),
        .q_i       (q_i),
        .done      (done),
        .err       (err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    // Timeline model: offset r from a handshake cycle; r=1..TOT is the busy window.
    function automatic bit in_seq(int r);
        return (r >= 1) && (r <= TOT);
    endfunction

    function automatic bit in_assert(int r);
        return (r >= S + 1) && (r <= S + A);
    endfunction

    // Expected {arst_o, ce_o, req_ready, done, err, rval_o} at cycle k after the first handshake.
    // fmode 1: bank readback corrupted during ASSERT; fmode 2: corrupted on the last RECOVER cycle.
    function automatic logic [12:0] exp_vec(int k, logic [7:0] v, logic [7:0] v2, bit second,
                                            int fmode, bit err0);
        int         r2;
        bit         busy;
        bit         a;
        bit         d;
        bit         e;
        logic [7:0] rv;
        r2   = second ? k - (TOT + 1) : -100;
        busy = in_seq(k) || in_seq(r2);
        a    = in_assert(k) || in_assert(r2);
        d    = (k == TOT + 1) || (r2 == TOT + 1);
        e    = err0 || (fmode == 1 && k > S + A) || (fmode == 2 && k > TOT);
        rv   = (r2 >= 1) ? v2 : v;
        return {a, !busy, !busy, d, e, rv};
    endfunction

    // Handshake v at k=0, then present v2 while busy (held valid if second) and record outputs.
    task automatic run_load(input logic [7:0] v, input logic [7:0] v2, input bit second,
                            input int fmode, input logic [7:0] fval);
        q_force_val = fval;
        for (int k = 0; k < NOBS; k++) begin
            if (k == 0) begin
                req_valid = 1'b1;
                req_value = v;
                q_force   = 1'b0;
            end else begin
                req_valid = second && (k <= TOT + 1);
                req_value = v2;
                q_force   = (fmode == 1 && in_assert(k)) || (fmode == 2 && k == TOT);
            end
            obs_vec[k] = {arst_o, ce_o, req_ready, done, err, rval_o};
            tick();
        end
        req_valid = 1'b0;
        q_force   = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        req_valid = 1'b1;
        req_value = 8'h77;
        tick();
        tick();
        rst       = 1'b0;
        req_valid = 1'b0;
        n_total++; if (arst_o !== 1'b0) $display("FAIL reset_arst got %b want 0", arst_o); else n_pass++;
        n_total++; if (ce_o !== 1'b1) $display("FAIL reset_ce got %b want 1", ce_o); else n_pass++;
        n_total++; if (req_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", req_ready); else n_pass++;
        n_total++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else n_pass++;
        n_total++; if (err !== 1'b0) $display("FAIL reset_err got %b want 0", err); else n_pass++;
        n_total++; if (rval_o !== 8'h00) $display("FAIL reset_rval got %h want 00", rval_o); else n_pass++;
    endtask

    task automatic test_basic();
        logic [12:0] e;
        run_load(8'hA5, 8'hA5, 1'b0, 0, 8'h00);
        for (int k = 1; k < NOBS; k++) begin
            e = exp_vec(k, 8'hA5, 8'hA5, 1'b0, 0, 1'b0);
            n_total++;
            if (obs_vec[k] !== e) $display("FAIL basic k=%0d got %h want %h", k, obs_vec[k], e);
            else n_pass++;
        end
    endtask

    task automatic test_value_change();
        logic [12:0] e;
        run_load(8'h3C, 8'hFF, 1'b0, 0, 8'h00);
        for (int k = 1; k < NOBS; k++) begin
            e = exp_vec(k, 8'h3C, 8'hFF, 1'b0, 0, 1'b0);
            n_total++;
            if (obs_vec[k] !== e) $display("FAIL value_change k=%0d got %h want %h", k, obs_vec[k], e);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        logic [12:0] e;
        run_load(8'h01, 8'h02, 1'b1, 0, 8'h00);
        for (int k = 1; k < NOBS; k++) begin
            e = exp_vec(k, 8'h01, 8'h02, 1'b1, 0, 1'b0);
            n_total++;
            if (obs_vec[k] !== e) $display("FAIL back_to_back k=%0d got %h want %h", k, obs_vec[k], e);
            else n_pass++;
        end
    endtask

    task automatic test_err_sticky();
        logic [12:0] e;
        run_load(8'h5A, 8'h5A, 1'b0, 1, 8'h00);
        for (int k = 1; k < NOBS; k++) begin
            e = exp_vec(k, 8'h5A, 8'h5A, 1'b0, 1, 1'b0);
            n_total++;
            if (obs_vec[k] !== e) $display("FAIL err_set k=%0d got %h want %h", k, obs_vec[k], e);
            else n_pass++;
        end
        run_load(8'h69, 8'h96, 1'b1, 0, 8'h00);
        for (int k = 1; k < NOBS; k++) begin
            e = exp_vec(k, 8'h69, 8'h96, 1'b1, 0, 1'b1);
            n_total++;
            if (obs_vec[k] !== e) $display("FAIL err_sticky k=%0d got %h want %h", k, obs_vec[k], e);
            else n_pass++;
        end
    endtask

    task automatic test_rst_mid();
        logic [12:0] e;
        logic [12:0] o;
        req_valid = 1'b1;
        req_value = 8'hB4;
        tick();
        req_valid = 1'b0;
        req_value = 8'h11;
        tick();
        n_total++;
        if (arst_o !== 1'b1) $display("FAIL rst_mid_pre_arst got %b want 1", arst_o); else n_pass++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        o = {arst_o, ce_o, req_ready, done, err, rval_o};
        n_total++;
        if (o !== 13'b0_1_1_0_0_00000000) $display("FAIL rst_mid_abort got %h want %h", o, 13'b0_1_1_0_0_00000000);
        else n_pass++;
        for (int k = 0; k < TOT + 2; k++) begin
            o = {arst_o, ce_o, req_ready, done, err, rval_o};
            n_total++;
            if (o !== 13'b0_1_1_0_0_00000000) $display("FAIL rst_mid_quiet k=%0d got %h want %h", k, o, 13'b0_1_1_0_0_00000000);
            else n_pass++;
            tick();
        end
        run_load(8'hC7, 8'hC7, 1'b0, 0, 8'h00);
        for (int k = 1; k < NOBS; k++) begin
            e = exp_vec(k, 8'hC7, 8'hC7, 1'b0, 0, 1'b0);
            n_total++;
            if (obs_vec[k] !== e) $display("FAIL rst_mid_after k=%0d got %h want %h", k, obs_vec[k], e);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        logic [12:0] e;
        logic [7:0]  v;
        logic [7:0]  v2;
        logic [7:0]  fval;
        bit          second;
        int          fmode;
        for (int it = 0; it < 20; it++) begin
            do_reset();
            v      = 8'($urandom);
            v2     = 8'($urandom);
            second = 1'($urandom_range(0, 1));
            fmode  = int'($urandom_range(0, 2));
            fval   = v ^ 8'($urandom_range(1, 255));
            run_load(v, v2, second, fmode, fval);
            for (int k = 1; k < NOBS; k++) begin
                e = exp_vec(k, v, v2, second, fmode, 1'b0);
                n_total++;
                if (obs_vec[k] !== e)
                    $display("FAIL random it=%0d k=%0d (v=%h v2=%h b2b=%0d f=%0d) got %h want %h",
                             it, k, v, v2, second, fmode, obs_vec[k], e);
                else n_pass++;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got no completion want $finish before 200000 time units");
        $fatal(1);
    end

    initial begin
        rst         = 1'b1;
        req_valid   = 1'b0;
        req_value   = '0;
        bank_d      = 8'hC3;
        q_force     = 1'b0;
        q_force_val = '0;
        test_reset();
        test_basic();
        test_value_change();
        test_back_to_back();
        test_err_sticky();
        test_rst_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
